// File: rtl/commit_sequencer_pkg.sv
// Shared definitions for the commit sequencer and the commit stage it feeds:
// tag/destination widths, sequencer state encoding and the tag-pack helper.
package commit_sequencer_pkg;
  localparam int CID_W  = 9;
  localparam int DEST_W = 4;
  localparam int CNT_W  = CID_W + 1;  // must hold 512 (frame_len 0)

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [CID_W-1:0]  cid;
    logic              flag;
  } tag_t;

  function automatic tag_t pack_tag(input logic [DEST_W-1:0] dest,
                                    input logic [CID_W-1:0]  cid,
                                    input logic              flag);
    tag_t t;
    t.dest = dest;
    t.cid  = cid;
    t.flag = flag;
    return t;
  endfunction
endpackage

// File: rtl/commit_sequencer_priority_match_select.sv
// priority_match_select: picks the lowest-index set bit of a match vector.
//   i_match  per-lane match
//   o_grant  one-hot grant (zero when no match)
//   o_dup    more than one lane matched
module priority_match_select #(
  parameter int n_lanes = 4
) (
  input  logic [n_lanes-1:0] i_match,
  output logic [n_lanes-1:0] o_grant,
  output logic               o_dup
);
  localparam logic [n_lanes-1:0] ONE = n_lanes'(1);

  // x & -x isolates the lowest set bit
  assign o_grant = i_match & (~i_match + ONE);
  assign o_dup   = |(i_match & ~o_grant);
endmodule

// File: rtl/commit_sequencer.sv
// commit_sequencer: forwards lane results to the commit stage strictly in
// ascending commit_id order (0..frame_len-1), one commit per cycle max.
//   i_clk, i_reset (async, active low), i_enable (low freezes everything)
//   i_frame_start/i_frame_len    start a frame (len 0 means 512)
//   i_lane_*  / o_lane_ready     per-lane request bundle and one-hot accept
//   o_out_valid / i_out_ready    valid/ready toward the commit stage
//   o_*_out                      registered payload of the committed lane
//   o_expected_id, o_frame_done, o_err_dup, o_err_stall   status
module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int n_blocks    = 256,
  parameter int n_lanes     = 4,
  parameter int stall_limit = 1023
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_enable,
  input  logic                                i_frame_start,
  input  logic [CID_W-1:0]                    i_frame_len,
  input  logic [n_lanes-1:0]                  i_lane_valid,
  output logic [n_lanes-1:0]                  o_lane_ready,
  input  logic [n_lanes*$clog2(n_blocks)-1:0] i_lane_block,
  input  logic [n_lanes*2*data_width-1:0]     i_lane_result,
  input  logic [n_lanes*DEST_W-1:0]           i_lane_dest,
  input  logic [n_lanes*CID_W-1:0]            i_lane_commit_id,
  input  logic [n_lanes-1:0]                  i_lane_commit_flag,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  output logic [$clog2(n_blocks)-1:0]         o_block_out,
  output logic [2*data_width-1:0]             o_result_out,
  output logic [DEST_W-1:0]                   o_dest_out,
  output logic [CID_W-1:0]                    o_commit_id_out,
  output logic                                o_commit_flag_out,
  output logic [CID_W-1:0]                    o_expected_id,
  output logic                                o_frame_done,
  output logic                                o_err_dup,
  output logic                                o_err_stall
);
  localparam int LB   = $clog2(n_blocks);
  localparam int RW   = 2 * data_width;
  localparam int WD_W = $clog2(stall_limit + 1);

  state_t           r_state, w_state_nxt;
  logic [CID_W-1:0] r_exp_id;
  logic [CNT_W-1:0] r_count, r_len, w_len;
  logic [WD_W-1:0]  r_wd;
  logic             r_out_valid, r_frame_done, r_err_dup, r_err_stall;
  logic [LB-1:0]    r_blk;
  logic [RW-1:0]    r_res;
  tag_t             r_tag;

  logic [n_lanes-1:0] w_match, w_grant;
  logic               w_dup, w_run_en, w_load, w_last, w_wd_exp;
  logic [LB-1:0]      w_blk;
  logic [RW-1:0]      w_res;
  logic [DEST_W-1:0]  w_dst;
  logic               w_flg;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < n_lanes; i++)
      w_match[i] = i_lane_valid[i] && (i_lane_commit_id[i*CID_W +: CID_W] == r_exp_id);
  end

  priority_match_select #(.n_lanes(n_lanes)) u_sel (
    .i_match (w_match),
    .o_grant (w_grant),
    .o_dup   (w_dup)
  );

  // frame_start wins over a load in the same cycle: the match was computed
  // against the old frame's expected_id.
  assign w_run_en = (r_state == ST_RUN) && i_enable;
  assign w_load   = w_run_en && !i_frame_start && (|w_match) && (!r_out_valid || i_out_ready);
  assign w_last   = (r_count == r_len - CNT_W'(1));
  assign w_wd_exp = w_run_en && !i_frame_start && !w_load && (|i_lane_valid) &&
                    (r_wd == WD_W'(stall_limit - 1));
  assign w_len    = (i_frame_len == '0) ? CNT_W'(1 << CID_W) : {1'b0, i_frame_len};

  assign o_lane_ready = w_load ? w_grant : '0;

  always_comb begin
    w_blk = '0;
    w_res = '0;
    w_dst = '0;
    w_flg = 1'b0;
    for (int i = 0; i < n_lanes; i++)
      if (w_grant[i]) begin
        w_blk = i_lane_block[i*LB +: LB];
        w_res = i_lane_result[i*RW +: RW];
        w_dst = i_lane_dest[i*DEST_W +: DEST_W];
        w_flg = i_lane_commit_flag[i];
      end
  end

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (i_enable) begin
      if (i_frame_start)
        w_state_nxt = ST_RUN;
      else if (r_state == ST_RUN && ((w_load && w_last) || w_wd_exp))
        w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_exp_id     <= '0;
      r_count      <= '0;
      r_len        <= '0;
      r_wd         <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_dup    <= 1'b0;
      r_err_stall  <= 1'b0;
      r_blk        <= '0;
      r_res        <= '0;
      r_tag        <= '0;
    end else begin
      r_frame_done <= w_load && w_last;
      if (i_enable) begin
        if (i_frame_start) begin
          r_exp_id    <= '0;
          r_count     <= '0;
          r_wd        <= '0;
          r_len       <= w_len;
          r_err_dup   <= 1'b0;
          r_err_stall <= 1'b0;
        end else if (r_state == ST_RUN) begin
          if (w_load) begin
            r_exp_id <= r_exp_id + CID_W'(1);
            r_count  <= r_count + CNT_W'(1);
            r_wd     <= '0;
          end else if (|i_lane_valid) begin
            r_wd <= w_wd_exp ? '0 : r_wd + WD_W'(1);
          end
          if (w_dup)    r_err_dup   <= 1'b1;
          if (w_wd_exp) r_err_stall <= 1'b1;
        end
        // output register: load and drain may coincide
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_blk       <= w_blk;
          r_res       <= w_res;
          r_tag       <= pack_tag(w_dst, r_exp_id, w_flg);
        end else if (i_out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_block_out       = r_blk;
  assign o_result_out      = r_res;
  assign o_dest_out        = r_tag.dest;
  assign o_commit_id_out   = r_tag.cid;
  assign o_commit_flag_out = r_tag.flag;
  assign o_expected_id     = r_exp_id;
  assign o_frame_done      = r_frame_done;
  assign o_err_dup         = r_err_dup;
  assign o_err_stall       = r_err_stall;
endmodule

// File: tb/tb_commit_sequencer.sv
module tb_commit_sequencer;
  import commit_sequencer_pkg::*;
  localparam int DW = 16, NB = 256, NL = 4, SL = 8, LB = 8, RW = 32;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, frame_start = 1'b0, out_ready = 1'b1;
  logic [8:0] frame_len = '0;
  logic [NL-1:0] lane_valid = '0, lane_flag = '0, lane_ready;
  logic [NL*LB-1:0] lane_block = '0;
  logic [NL*RW-1:0] lane_result = '0;
  logic [NL*4-1:0] lane_dest = '0;
  logic [NL*9-1:0] lane_cid = '0;
  logic out_valid, flag_out, frame_done, err_dup, err_stall;
  logic [LB-1:0] block_out;
  logic [RW-1:0] result_out;
  logic [3:0] dest_out;
  logic [8:0] cid_out, expected_id;

  always #5 clk = ~clk;

  commit_sequencer #(.data_width(DW), .n_blocks(NB), .n_lanes(NL), .stall_limit(SL)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(enable), .i_frame_start(frame_start),
    .i_frame_len(frame_len), .i_lane_valid(lane_valid), .o_lane_ready(lane_ready),
    .i_lane_block(lane_block), .i_lane_result(lane_result), .i_lane_dest(lane_dest),
    .i_lane_commit_id(lane_cid), .i_lane_commit_flag(lane_flag), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_block_out(block_out), .o_result_out(result_out),
    .o_dest_out(dest_out), .o_commit_id_out(cid_out), .o_commit_flag_out(flag_out),
    .o_expected_id(expected_id), .o_frame_done(frame_done), .o_err_dup(err_dup),
    .o_err_stall(err_stall));

  typedef struct {int cid; logic [LB-1:0] blk; logic [RW-1:0] res; logic [3:0] dest; logic flag;} item_t;
  typedef struct {int len; int ids[NL]; int exp_commits; int exp_done; int exp_final; int exp_span;} vec_t;

  item_t lq[NL][$];
  item_t expq[$];
  int checks = 0, errors = 0, commits = 0, done_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

  function automatic item_t mk(int lane, int cid);
    item_t t;
    t.cid  = cid;
    t.blk  = LB'(cid * 3 + lane);
    t.res  = RW'(32'hA000_0000 ^ (cid << 8) ^ lane);
    t.dest = 4'(lane + cid);
    t.flag = 1'(cid & 1);
    return t;
  endfunction

  function automatic logic [63:0] word_of(item_t t);
    return 64'({t.blk, t.res, t.dest, 9'(t.cid), t.flag});
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  wire [63:0] w_word = 64'({block_out, result_out, dest_out, cid_out, flag_out});

  // lane model: each lane holds its head item until handshaked
  logic [NL-1:0] hs;
  always begin
    @(negedge clk);
    hs = lane_valid & lane_ready;
    @(posedge clk);
    #2;
    for (int i = 0; i < NL; i++) begin
      if (hs[i] && lq[i].size() > 0) void'(lq[i].pop_front());
      if (lq[i].size() > 0) begin
        lane_valid[i] = 1'b1;
        lane_block[i*LB +: LB] = lq[i][0].blk;
        lane_result[i*RW +: RW] = lq[i][0].res;
        lane_dest[i*4 +: 4] = lq[i][0].dest;
        lane_cid[i*9 +: 9] = 9'(lq[i][0].cid);
        lane_flag[i] = lq[i][0].flag;
      end else begin
        lane_valid[i] = 1'b0;
        lane_block[i*LB +: LB] = '0;
        lane_result[i*RW +: RW] = '0;
        lane_dest[i*4 +: 4] = '0;
        lane_cid[i*9 +: 9] = '0;
        lane_flag[i] = 1'b0;
      end
    end
  end

  // monitor: scoreboard compare on each accepted output word
  logic hold_v = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    item_t e;
    cyc++;
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if (hold_v && out_valid) chk("hold_stable", w_word, held);
      hold_v = out_valid && !out_ready;
      held = w_word;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got id %0d expected none", cid_out);
        end else begin
          e = expq.pop_front();
          chk("commit_id", 64'(cid_out), 64'(e.cid));
          chk("commit_payload", w_word, word_of(e));
        end
        if (commits == 0) first_cyc = cyc;
        last_cyc = cyc;
        commits++;
      end
    end else hold_v = 1'b0;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int len);
    frame_len = 9'(len);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    commits = 0;
    done_cnt = 0;
  endtask

  task automatic wait_drain(int maxc, string name);
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < maxc) begin
      tick(1);
      n++;
    end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, expq.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    item_t e;
    int n;
    vt[0] = '{4, '{3, 2, 1, 0}, 4, 1, 4, 3};
    vt[1] = '{4, '{0, 1, 2, 3}, 4, 1, 4, 3};
    vt[2] = '{2, '{1, 0, -1, -1}, 2, 1, 2, 1};
    vt[3] = '{3, '{2, -1, 0, 1}, 3, 1, 3, 2};

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_lane_ready", 64'(lane_ready), 0);
    chk("rst_expected_id", 64'(expected_id), 0);
    chk("rst_flags", 64'({frame_done, err_dup, err_stall}), 0);
    chk("rst_payload", w_word, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NL; i++)
        if (vt[v].ids[i] >= 0) lq[i].push_back(mk(i, vt[v].ids[i]));
      for (int id = 0; id < vt[v].len; id++)
        for (int i = 0; i < NL; i++)
          if (vt[v].ids[i] == id) expq.push_back(mk(i, id));
      start_frame(vt[v].len);
      wait_drain(20, "vec");
      tick(1);
      chk("vec_commits", 64'(commits), 64'(vt[v].exp_commits));
      chk("vec_frame_done", 64'(done_cnt), 64'(vt[v].exp_done));
      chk("vec_expected_id", 64'(expected_id), 64'(vt[v].exp_final));
      chk("vec_span", 64'(last_cyc - first_cyc), 64'(vt[v].exp_span));
    end

    // back-pressure mid-frame
    for (int id = 0; id < 8; id++) begin
      lq[0].push_back(mk(0, id));
      expq.push_back(mk(0, id));
    end
    start_frame(8);
    n = 0;
    while (commits < 3 && n < 20) begin tick(1); n++; end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("bp_lane_ready", 64'(lane_ready), 0);
      chk("bp_out_valid", 64'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_drain(30, "bp");
    tick(1);
    chk("bp_commits", 64'(commits), 8);
    chk("bp_frame_done", 64'(done_cnt), 1);

    // duplicate tag: lane1 wins, lane2 waits until retagged
    lq[1].push_back(mk(1, 0));
    lq[2].push_back(mk(2, 0));
    expq.push_back(mk(1, 0));
    start_frame(2);
    tick(3);
    chk("dup_err", 64'(err_dup), 1);
    chk("dup_lane2_pending", 64'(lq[2].size()), 1);
    chk("dup_commits", 64'(commits), 1);
    chk("dup_expected_id", 64'(expected_id), 1);
    lq[2][0].cid = 1;
    e = lq[2][0];
    expq.push_back(e);
    wait_drain(20, "dup");
    tick(1);
    chk("dup_commits_final", 64'(commits), 2);
    chk("dup_frame_done", 64'(done_cnt), 1);
    chk("dup_sticky", 64'(err_dup), 1);

    // watchdog
    lq[0].push_back(mk(0, 5));
    start_frame(4);
    chk("wd_dup_cleared", 64'(err_dup), 0);
    tick(7);
    chk("wd_before_limit", 64'(err_stall), 0);
    tick(1);
    chk("wd_at_limit", 64'(err_stall), 1);
    chk("wd_expected_id", 64'(expected_id), 0);
    lq[0][0].cid = 0;
    tick(2);
    chk("wd_idle_no_grant", 64'(lane_ready), 0);
    chk("wd_idle_no_commit", 64'({out_valid, 8'(commits)}), 0);
    lq[0].delete();
    tick(1);

    // frame_len 0 -> 512 commits with id wrap
    for (int id = 0; id < 512; id++) begin
      lq[0].push_back(mk(0, id));
      expq.push_back(mk(0, id));
    end
    start_frame(0);
    chk("wrap_stall_cleared", 64'(err_stall), 0);
    wait_drain(600, "wrap");
    tick(1);
    chk("wrap_commits", 64'(commits), 512);
    chk("wrap_frame_done", 64'(done_cnt), 1);
    chk("wrap_expected_id", 64'(expected_id), 0);
    chk("wrap_span", 64'(last_cyc - first_cyc), 511);

    // reset mid-frame with a held output word
    out_ready = 1'b0;
    for (int id = 0; id < 8; id++) lq[0].push_back(mk(0, id));
    expq.push_back(mk(0, 0));
    start_frame(8);
    tick(2);
    chk("rstm_held_valid", 64'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_out_valid", 64'(out_valid), 0);
    chk("rstm_lane_ready", 64'(lane_ready), 0);
    chk("rstm_payload", w_word, 0);
    chk("rstm_status", 64'({expected_id, frame_done, err_dup, err_stall}), 0);
    expq.delete();
    lq[0].delete();
    out_ready = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int id = 0; id < 2; id++) begin
      lq[0].push_back(mk(0, id));
      expq.push_back(mk(0, id));
    end
    start_frame(2);
    wait_drain(20, "rstm");
    tick(1);
    chk("rstm_restart_commits", 64'(commits), 2);
    chk("rstm_restart_expected", 64'(expected_id), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
